// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - serial voice mixer: snapshot, per-voice volume, master shift, saturate
// Optional feature: define MIXER_CLIP_COUNT_EN to add the 16-bit saturating clip counter.
module voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int BITDEPTH   = 14
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_clock,
  input  logic [NUM_VOICES*BITDEPTH-1:0] voice_in,
  input  logic [3:0]                     addr,
  input  logic [31:0]                    data_in,
  input  logic                           wen,
  input  logic                           ren,
  output logic [31:0]                    data_out,
  output logic                           ready,
  output logic [BITDEPTH-1:0]            pcm,
  output logic                           pcm_valid,
  output logic                           overrun
);
  localparam int ACC_W  = BITDEPTH + 9 + $clog2(NUM_VOICES);
  localparam int PROD_W = BITDEPTH + 9;
  localparam logic signed [ACC_W-1:0] PMAX = ACC_W'((2 ** (BITDEPTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] PMIN = ACC_W'(-(2 ** (BITDEPTH - 1)));

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_OUTPUT = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [3:0]              idx_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [BITDEPTH-1:0]     snap_q [NUM_VOICES];
  logic [7:0]              vol_q  [NUM_VOICES];
  logic [2:0]              shift_q;
  logic                    overrun_q, sc_q, ready_q, pcm_valid_q;
  logic [BITDEPTH-1:0]     pcm_q;
  logic [31:0]             data_out_q, rd_data;
  logic [15:0]             clip_cnt;

  logic                     tick, last, frame_done, wr_commit, clr_overrun, clip_hi, clip_lo;
  logic [BITDEPTH-1:0]      sample_cur, clamped, pcm_d;
  logic [7:0]               vol_cur;
  logic signed [BITDEPTH-1:0] s_cur;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum, shifted;
  logic                     unused_ok;

  assign tick        = sample_clock & ~sc_q;
  assign last        = (idx_q == 4'(NUM_VOICES - 1));
  assign frame_done  = (state_q == S_ACCUM) && last;
  assign wr_commit   = wen & ~ready_q;
  assign clr_overrun = wr_commit && (addr == 4'hE) && data_in[8];
  assign unused_ok   = ^{data_in[31:9], data_in[7:3]};

  // Volume is read live from the register file for the voice being accumulated.
  always_comb begin
    sample_cur = '0;
    vol_cur    = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (idx_q == 4'(i)) begin
        sample_cur = snap_q[i];
        vol_cur    = vol_q[i];
      end
    end
    s_cur   = {~sample_cur[BITDEPTH-1], sample_cur[BITDEPTH-2:0]};
    prod    = PROD_W'(s_cur) * PROD_W'($signed({1'b0, vol_cur}));
    acc_sum = acc_q + ACC_W'(prod);
    shifted = acc_sum >>> (4'd8 + {1'b0, shift_q});
    clip_hi = (shifted > PMAX);
    clip_lo = (shifted < PMIN);
    if (clip_hi)      clamped = {1'b0, {(BITDEPTH-1){1'b1}}};
    else if (clip_lo) clamped = {1'b1, {(BITDEPTH-1){1'b0}}};
    else              clamped = shifted[BITDEPTH-1:0];
    pcm_d = {~clamped[BITDEPTH-1], clamped[BITDEPTH-2:0]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tick) state_d = S_ACCUM;
      S_ACCUM: if (last) state_d = S_OUTPUT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      pcm_q       <= {1'b1, {(BITDEPTH-1){1'b0}}};
      pcm_valid_q <= 1'b0;
      sc_q        <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) snap_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sc_q        <= sample_clock;
      pcm_valid_q <= 1'b0;
      if (state_q == S_IDLE && tick) begin
        for (int i = 0; i < NUM_VOICES; i++) snap_q[i] <= voice_in[i*BITDEPTH +: BITDEPTH];
        acc_q <= '0;
        idx_q <= '0;
      end else if (state_q == S_ACCUM) begin
        acc_q <= acc_sum;
        idx_q <= idx_q + 4'd1;
        if (last) begin
          pcm_q       <= pcm_d;
          pcm_valid_q <= 1'b1;
        end
      end
    end
  end

`ifdef MIXER_CLIP_COUNT_EN
  logic [15:0] clip_cnt_q;
  assign clip_cnt = clip_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_cnt_q <= '0;
    end else begin
      if (clr_overrun) clip_cnt_q <= '0;
      if (frame_done && (clip_hi || clip_lo) && clip_cnt_q != 16'hFFFF)
        clip_cnt_q <= clip_cnt_q + 16'd1;
    end
  end
`else
  assign clip_cnt = 16'h0000;
`endif

  always_comb begin
    rd_data = '0;
    case (addr)
      4'hE:    rd_data = {29'b0, shift_q};
      4'hF:    rd_data = {clip_cnt, 15'b0, overrun_q};
      default: begin
        for (int i = 0; i < NUM_VOICES; i++)
          if (addr == 4'(i)) rd_data = {24'b0, vol_q[i]};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) vol_q[i] <= 8'h80;
      shift_q    <= '0;
      overrun_q  <= 1'b0;
      ready_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      ready_q <= wen | ren;
      if (wr_commit) begin
        for (int i = 0; i < NUM_VOICES; i++)
          if (addr == 4'(i)) vol_q[i] <= data_in[7:0];
        if (addr == 4'hE) shift_q <= data_in[2:0];
      end
      // Set after clear so a same-cycle overrun is not lost.
      if (clr_overrun) overrun_q <= 1'b0;
      if (tick && state_q != S_IDLE) overrun_q <= 1'b1;
      if (ren) data_out_q <= rd_data;
    end
  end

  assign ready     = ready_q & (wen | ren);
  assign data_out  = data_out_q;
  assign pcm       = pcm_q;
  assign pcm_valid = pcm_valid_q;
  assign overrun   = overrun_q;
endmodule
